// File: rtl/player_bullet_if.sv
// player_bullet_if
// Shot bus between the player bullet (producer) and the alien group (consumer).
// The producer publishes the bullet position and flight status; the consumer
// reports a hit, which retires the bullet.
interface player_bullet_if;
   logic               bullet_active;
   logic signed [11:0] bullet_x;
   logic signed [11:0] bullet_y;
   logic               alien_hit;

   modport master (
      output bullet_active,
      output bullet_x,
      output bullet_y,
      input  alien_hit
   );

   modport slave (
      input  bullet_active,
      input  bullet_x,
      input  bullet_y,
      output alien_hit
   );
endinterface

// File: rtl/player_bullet.sv
// player_bullet
// Player-side shot generator. A fire request is latched, the bullet launches
// from the ship on the next frame start and climbs SPEED pixels per frame until
// it leaves the top edge or an alien reports a hit. After retirement a cooldown
// of COOLDOWN_FRAMES frames blocks the next launch. The bullet is also rendered
// into the pixel stream with one cycle of latency from hpos/vpos.
//
// Build option: PLAYER_BULLET_FIRE_BUFFER_EN
//   defined     - fire seen in flight or cooldown is buffered (one shot max) and
//                 launches on the first frame start after returning to IDLE.
//   not defined - fire is only sampled while IDLE.
module player_bullet #(
   parameter int          BULLET_W        = 2,
   parameter int          BULLET_H        = 8,
   parameter int          SPEED           = 6,
   parameter int          TOP_Y           = 0,
   parameter int          COOLDOWN_FRAMES = 4,
   parameter logic [23:0] COLOR           = 24'hFFFF00
) (
   input  logic                pixel_clk,
   input  logic                rst,
   input  logic                fsync,
   input  logic signed [11:0]  hpos,
   input  logic signed [11:0]  vpos,
   input  logic                fire,
   input  logic signed [11:0]  ship_x,
   input  logic signed [11:0]  ship_y,
   player_bullet_if.master     bus,
   output logic [15:0]         shots_fired,
   output logic [7:0]          pixel [0:2],
   output logic                active
);

   // Cooldown counter just wide enough to hold COOLDOWN_FRAMES.
   localparam int CNT_W = (COOLDOWN_FRAMES > 1) ? $clog2(COOLDOWN_FRAMES + 1) : 1;

   localparam logic signed [12:0] TOP_Y_13  = 13'(TOP_Y);
   localparam logic        [12:0] SPEED_13  = 13'(SPEED);
   localparam logic        [12:0] HALF_W_13 = 13'(BULLET_W / 2);
   localparam logic        [12:0] W_13      = 13'(BULLET_W);
   localparam logic        [12:0] H_13      = 13'(BULLET_H);
   localparam logic        [11:0] H_12      = 12'(BULLET_H);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      FLIGHT   = 2'd1,
      COOLDOWN = 2'd2
   } state_t;

   state_t             state_reg;
   logic               pending_reg;
   logic [CNT_W-1:0]   cnt_reg;
   logic               bullet_active_reg;
   logic signed [11:0] bullet_x_reg;
   logic signed [11:0] bullet_y_reg;
   logic [15:0]        shots_reg;

   logic signed [12:0] y_step;
   logic               top_exit;
   logic               retire_now;
   logic               launch_now;

   logic signed [12:0] box_x_lo;
   logic signed [12:0] box_x_hi;
   logic signed [12:0] box_y_lo;
   logic signed [12:0] box_y_hi;
   logic signed [12:0] hpos_13;
   logic signed [12:0] vpos_13;
   logic               in_box;
   logic               active_reg;

   // Next-frame position in 13 bits so a step above the top edge stays negative.
   always_comb begin
      y_step     = {bullet_y_reg[11], bullet_y_reg} - SPEED_13;
      top_exit   = (y_step < TOP_Y_13);
      retire_now = (state_reg == FLIGHT) && (bus.alien_hit || (fsync && top_exit));
      launch_now = (state_reg == IDLE) && fsync && (pending_reg || fire);
   end

   // Shot FSM: launch, per-frame climb, retirement and cooldown.
   always_ff @(posedge pixel_clk) begin
      if (rst) begin
         state_reg         <= IDLE;
         pending_reg       <= 1'b0;
         cnt_reg           <= '0;
         bullet_active_reg <= 1'b0;
         bullet_x_reg      <= '0;
         bullet_y_reg      <= '0;
         shots_reg         <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (launch_now) begin
                  state_reg         <= FLIGHT;
                  pending_reg       <= 1'b0;
                  bullet_active_reg <= 1'b1;
                  bullet_x_reg      <= ship_x;
                  bullet_y_reg      <= ship_y - H_12;
                  if (shots_reg != 16'hFFFF)
                     shots_reg <= shots_reg + 16'd1;
               end else if (fire) begin
                  pending_reg <= 1'b1;
               end
            end

            FLIGHT: begin
`ifdef PLAYER_BULLET_FIRE_BUFFER_EN
               if (fire)
                  pending_reg <= 1'b1;
`endif
               // A hit in the same cycle as frame start wins: no move.
               if (retire_now) begin
                  bullet_active_reg <= 1'b0;
                  cnt_reg           <= CNT_W'(COOLDOWN_FRAMES);
                  state_reg         <= (COOLDOWN_FRAMES == 0) ? IDLE : COOLDOWN;
               end else if (fsync) begin
                  bullet_y_reg <= y_step[11:0];
               end
            end

            COOLDOWN: begin
`ifdef PLAYER_BULLET_FIRE_BUFFER_EN
               if (fire)
                  pending_reg <= 1'b1;
`endif
               if (fsync) begin
                  cnt_reg <= cnt_reg - CNT_W'(1);
                  if (cnt_reg <= CNT_W'(1))
                     state_reg <= IDLE;
               end
            end

            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign bus.bullet_active = bullet_active_reg;
   assign bus.bullet_x      = bullet_x_reg;
   assign bus.bullet_y      = bullet_y_reg;
   assign shots_fired       = shots_reg;

   // Bullet bounding box against the current scan position, widened to 13 bits.
   always_comb begin
      hpos_13  = {hpos[11], hpos};
      vpos_13  = {vpos[11], vpos};
      box_x_lo = {bullet_x_reg[11], bullet_x_reg} - HALF_W_13;
      box_x_hi = box_x_lo + W_13;
      box_y_lo = {bullet_y_reg[11], bullet_y_reg};
      box_y_hi = box_y_lo + H_13;
      in_box   = bullet_active_reg &&
                 (hpos_13 >= box_x_lo) && (hpos_13 < box_x_hi) &&
                 (vpos_13 >= box_y_lo) && (vpos_13 < box_y_hi);
   end

   // Registered coverage flag.
   always_ff @(posedge pixel_clk) begin
      if (rst)
         active_reg <= 1'b0;
      else
         active_reg <= in_box;
   end

   assign active = active_reg;

   // One registered colour channel per generate slice: R, G, B.
   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_chan
         logic [7:0] chan_reg;

         // Channel value when the bullet covers the scan position, else black.
         always_ff @(posedge pixel_clk) begin
            if (rst)
               chan_reg <= 8'h00;
            else
               chan_reg <= in_box ? COLOR[23 - 8*gi -: 8] : 8'h00;
         end

         assign pixel[gi] = chan_reg;
      end
   endgenerate

endmodule

// File: tb/tb_player_bullet.sv
// tb_player_bullet
// Directed bench for player_bullet: reset, launch, render window, top exit,
// hit with cooldown (both fire-buffer builds), reset mid-flight and the
// hit-versus-frame-start ordering.
`timescale 1ns/1ps
module tb_player_bullet;

   logic               clk;
   logic               rst;
   logic               fsync;
   logic signed [11:0] hpos;
   logic signed [11:0] vpos;
   logic               fire;
   logic signed [11:0] ship_x;
   logic signed [11:0] ship_y;
   logic [15:0]        shots_fired;
   logic [7:0]         pixel [0:2];
   logic               active;

   int n_cmp;
   int n_err;
   int exp_y;

   player_bullet_if bus_i ();

   player_bullet dut (
      .pixel_clk   (clk),
      .rst         (rst),
      .fsync       (fsync),
      .hpos        (hpos),
      .vpos        (vpos),
      .fire        (fire),
      .ship_x      (ship_x),
      .ship_y      (ship_y),
      .bus         (bus_i),
      .shots_fired (shots_fired),
      .pixel       (pixel),
      .active      (active)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic fs;
      int   h;
      int   v;
      int   y;
      logic a;
   } vec_t;

   vec_t vecs [0:12];

   task automatic check(input string name, input int act, input int req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end else begin
         $display("ok   %s: %0d", name, act);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One idle cycle (optionally with fire held) followed by one fsync cycle.
   task automatic pulse(input logic f);
      fire  = f;
      fsync = 1'b0;
      step();
      fire  = 1'b0;
      fsync = 1'b1;
      step();
      fsync = 1'b0;
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst = 1'b1; fsync = 1'b0; fire = 1'b0;
      hpos = 12'sd0; vpos = 12'sd0;
      ship_x = 12'sd320; ship_y = 12'sd440;
      bus_i.alien_hit = 1'b0;

      vecs[0]  = '{1'b0, 319, 432, 432, 1'b1};
      vecs[1]  = '{1'b0, 320, 439, 432, 1'b1};
      vecs[2]  = '{1'b0, 321, 432, 432, 1'b0};
      vecs[3]  = '{1'b0, 320, 440, 432, 1'b0};
      vecs[4]  = '{1'b0, 318, 435, 432, 1'b0};
      vecs[5]  = '{1'b0, 320, 431, 432, 1'b0};
      vecs[6]  = '{1'b1, 320, 432, 426, 1'b1};
      vecs[7]  = '{1'b0, 320, 426, 426, 1'b1};
      vecs[8]  = '{1'b0, 320, 425, 426, 1'b0};
      vecs[9]  = '{1'b0, 319, 433, 426, 1'b1};
      vecs[10] = '{1'b0, 320, 434, 426, 1'b0};
      vecs[11] = '{1'b1, 320, 434, 420, 1'b0};
      vecs[12] = '{1'b0, 320, 427, 420, 1'b1};

      // Reset
      step(); step();
      check("rst_active_flag", int'(bus_i.bullet_active), 0);
      check("rst_x", int'(bus_i.bullet_x), 0);
      check("rst_y", int'(bus_i.bullet_y), 0);
      check("rst_shots", int'(shots_fired), 0);
      check("rst_active", int'(active), 0);
      check("rst_pix_r", int'(pixel[0]), 0);
      check("rst_pix_b", int'(pixel[2]), 0);
      rst = 1'b0;

      // Launch: fire latched, then frame start
      fire = 1'b1; step(); fire = 1'b0;
      step();
      check("pre_launch_active", int'(bus_i.bullet_active), 0);
      fsync = 1'b1; step(); fsync = 1'b0;
      check("launch_active", int'(bus_i.bullet_active), 1);
      check("launch_x", int'(bus_i.bullet_x), 320);
      check("launch_y", int'(bus_i.bullet_y), 432);
      check("launch_shots", int'(shots_fired), 1);

      // Render window and per-frame climb, table driven
      for (int i = 0; i < 13; i++) begin
         fsync = vecs[i].fs;
         hpos  = 12'(vecs[i].h);
         vpos  = 12'(vecs[i].v);
         step();
         fsync = 1'b0;
         check($sformatf("vec%0d_y", i), int'(bus_i.bullet_y), vecs[i].y);
         check($sformatf("vec%0d_active", i), int'(active), int'(vecs[i].a));
         check($sformatf("vec%0d_pix_r", i), int'(pixel[0]), vecs[i].a ? 255 : 0);
         check($sformatf("vec%0d_pix_g", i), int'(pixel[1]), vecs[i].a ? 255 : 0);
         check($sformatf("vec%0d_pix_b", i), int'(pixel[2]), 0);
      end
      hpos = 12'sd0; vpos = 12'sd0;

      // Top exit: climb from 420 down to 0, then one more frame retires
      exp_y = 420;
      for (int i = 0; i < 70; i++) begin
         pulse(1'b0);
         exp_y -= 6;
         check($sformatf("climb%0d_y", i), int'(bus_i.bullet_y), exp_y);
      end
      check("climb_still_active", int'(bus_i.bullet_active), 1);
      pulse(1'b0);
      check("top_exit_active", int'(bus_i.bullet_active), 0);
      check("top_exit_y_hold", int'(bus_i.bullet_y), 0);
      check("top_exit_x_hold", int'(bus_i.bullet_x), 320);
      for (int i = 0; i < 4; i++) begin
         pulse(1'b0);
         check($sformatf("cool%0d_active", i), int'(bus_i.bullet_active), 0);
      end
      ship_x = 12'sd100; ship_y = 12'sd200;
      fire = 1'b1; step(); fire = 1'b0;
      pulse(1'b0);
      check("relaunch_active", int'(bus_i.bullet_active), 1);
      check("relaunch_x", int'(bus_i.bullet_x), 100);
      check("relaunch_y", int'(bus_i.bullet_y), 192);
      check("relaunch_shots", int'(shots_fired), 2);

      // Hit, then fire during each cooldown frame
      bus_i.alien_hit = 1'b1; step(); bus_i.alien_hit = 1'b0;
      check("hit_active", int'(bus_i.bullet_active), 0);
      check("hit_y_hold", int'(bus_i.bullet_y), 192);
      for (int i = 0; i < 4; i++) begin
         pulse(1'b1);
         check($sformatf("hit_cool%0d_active", i), int'(bus_i.bullet_active), 0);
      end
      pulse(1'b0);
`ifdef PLAYER_BULLET_FIRE_BUFFER_EN
      check("fifth_fsync_active", int'(bus_i.bullet_active), 1);
      check("fifth_fsync_shots", int'(shots_fired), 3);
`else
      check("fifth_fsync_active", int'(bus_i.bullet_active), 0);
      check("fifth_fsync_shots", int'(shots_fired), 2);
`endif

      // Reset while possibly in flight
      rst = 1'b1; step(); rst = 1'b0;
      check("rst2_active", int'(bus_i.bullet_active), 0);
      check("rst2_shots", int'(shots_fired), 0);
      check("rst2_y", int'(bus_i.bullet_y), 0);

      // fire and fsync in the same cycle launch immediately
      ship_x = 12'sd50; ship_y = 12'sd308;
      fire = 1'b1; fsync = 1'b1; step(); fire = 1'b0; fsync = 1'b0;
      check("same_cycle_launch_active", int'(bus_i.bullet_active), 1);
      check("same_cycle_launch_y", int'(bus_i.bullet_y), 300);
      check("same_cycle_launch_x", int'(bus_i.bullet_x), 50);
      check("same_cycle_launch_shots", int'(shots_fired), 1);

      // Hit and frame start together: hit wins, no move
      bus_i.alien_hit = 1'b1; fsync = 1'b1; step();
      bus_i.alien_hit = 1'b0; fsync = 1'b0;
      check("collide_active", int'(bus_i.bullet_active), 0);
      check("collide_y", int'(bus_i.bullet_y), 300);
      pulse(1'b0);
      check("collide_y_after_frame", int'(bus_i.bullet_y), 300);
      check("collide_still_off", int'(bus_i.bullet_active), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
